// File: rtl/act_transposer.sv
// Activation transposer: collects one frame of 3 images x NUM_NEURONS 4-bit activations,
// then emits one beat per neuron carrying that neuron's value from all three images.
module act_transposer #(
    parameter int NUM_NEURONS = 16,
    parameter int NUM_IMAGES  = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [63:0] a_tdata,
    input  logic        a_tvalid,
    output logic        a_tready,
    output logic [11:0] x_tdata,
    output logic        x_tvalid,
    input  logic        x_tready,
    output logic        x_tlast,
    output logic [1:0]  status
);
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [NW-1:0] LAST_NEU = NW'(NUM_NEURONS - 1);
    localparam logic [1:0]    LAST_IMG = 2'(NUM_IMAGES - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [1:0]    img_q, img_d;
    logic [NW-1:0] neu_q, neu_d;
    logic [NW-1:0] n_q, n_d;
    logic          armed_q, armed_d;
    logic [3:0]    frame_q [NUM_IMAGES][NUM_NEURONS];
    logic [3:0]    frame_d [NUM_IMAGES][NUM_NEURONS];
    logic          a_fire, x_fire;
    logic          unused_hi;

    assign unused_hi = ^a_tdata[63:4];

    always_comb begin
        state_d = state_q;
        img_d   = img_q;
        neu_d   = neu_q;
        n_d     = n_q;
        armed_d = 1'b1;
        frame_d = frame_q;

        // armed_q keeps a_tready low until the first edge after reset release
        a_tready = (state_q == FILL) && armed_q;
        x_tvalid = (state_q == DRAIN);
        a_fire   = a_tvalid && a_tready;
        x_fire   = x_tvalid && x_tready;

        if (a_fire) begin
            frame_d[img_q][neu_q] = a_tdata[3:0];
            if (neu_q == LAST_NEU) begin
                neu_d = '0;
                if (img_q == LAST_IMG) begin
                    img_d   = '0;
                    state_d = DRAIN;
                end else begin
                    img_d = img_q + 2'd1;
                end
            end else begin
                neu_d = neu_q + NW'(1);
            end
        end

        if (x_fire) begin
            if (n_q == LAST_NEU) begin
                n_d     = '0;
                state_d = FILL;
            end else begin
                n_d = n_q + NW'(1);
            end
        end

        x_tlast = x_tvalid && (n_q == LAST_NEU);
        x_tdata = '0;
        if (x_tvalid) begin
            x_tdata = {frame_q[2][n_q], frame_q[1][n_q], frame_q[0][n_q]};
        end

        if (state_q == DRAIN) begin
            status = 2'b10;
        end else if ((img_q != '0) || (neu_q != '0)) begin
            status = 2'b01;
        end else begin
            status = 2'b00;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= FILL;
            img_q   <= '0;
            neu_q   <= '0;
            n_q     <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            img_q   <= img_d;
            neu_q   <= neu_d;
            n_q     <= n_d;
            armed_q <= armed_d;
        end
    end

    // Frame storage is not reset; a partial frame is simply overwritten by the next one.
    always_ff @(posedge CLK) begin
        frame_q <= frame_d;
    end

endmodule

// File: tb/tb_act_transposer.sv
// Self-checking bench for act_transposer: constant-pattern table, hand-written corner
// sequences and random frames checked against a transpose reference model.
module tb_act_transposer;
    localparam int N     = 16;
    localparam int BEATS = 3 * N;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [63:0] a_tdata = '0;
    logic        a_tvalid = 1'b0;
    logic        a_tready;
    logic [11:0] x_tdata;
    logic        x_tvalid;
    logic        x_tready = 1'b0;
    logic        x_tlast;
    logic [1:0]  status;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] frame [BEATS];
    logic [11:0] expv  [N];

    typedef struct {
        string       name;
        logic [63:0] w0;
        logic [63:0] w1;
        logic [63:0] w2;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl [4];

    act_transposer #(.NUM_NEURONS(N), .NUM_IMAGES(3)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .a_tdata  (a_tdata),
        .a_tvalid (a_tvalid),
        .a_tready (a_tready),
        .x_tdata  (x_tdata),
        .x_tvalid (x_tvalid),
        .x_tready (x_tready),
        .x_tlast  (x_tlast),
        .status   (status)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: output beat n gathers neuron n of each image from the arrival order.
    function automatic void build_expect();
        for (int n = 0; n < N; n++) begin
            expv[n] = {frame[2*N+n][3:0], frame[N+n][3:0], frame[n][3:0]};
        end
    endfunction

    task automatic push_beat(input logic [63:0] d);
        int cyc;
        cyc = 0;
        a_tdata  = d;
        a_tvalid = 1'b1;
        while (!a_tready && cyc < 50) begin
            @(posedge CLK); #1;
            cyc++;
        end
        chk("a_tready_wait", 64'(a_tready), 64'(1'b1));
        @(posedge CLK); #1;
        a_tvalid = 1'b0;
    endtask

    task automatic push_frame(input bit gaps);
        chk("status_empty", 64'(status), 64'(2'b00));
        for (int i = 0; i < BEATS; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge CLK); #1;
                end
            end
            push_beat(frame[i]);
            if (i == 0) chk("status_filling", 64'(status), 64'(2'b01));
        end
        chk("x_tvalid_after_last_in", 64'(x_tvalid), 64'(1'b1));
        chk("a_tready_after_last_in", 64'(a_tready), 64'(1'b0));
        chk("status_draining", 64'(status), 64'(2'b10));
        build_expect();
    endtask

    task automatic drain_frame(input int stall_at, input bit rnd);
        int n;
        int cyc;
        int stall;
        bit rdy;
        n = 0; cyc = 0; stall = 0;
        while (n < N && cyc < 400) begin
            if (n == stall_at && stall < 3) begin
                rdy = 1'b0;
                stall++;
            end else begin
                rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            x_tready = rdy;
            @(negedge CLK);
            chk("x_tvalid", 64'(x_tvalid), 64'(1'b1));
            chk("x_tdata", 64'(x_tdata), 64'(expv[n]));
            chk("x_tlast", 64'(x_tlast), 64'(n == N - 1));
            chk("a_tready_in_drain", 64'(a_tready), 64'(1'b0));
            @(posedge CLK); #1;
            if (rdy) n++;
            cyc++;
        end
        x_tready = 1'b0;
        chk("drain_count", 64'(n), 64'(N));
        chk("x_tvalid_after_drain", 64'(x_tvalid), 64'(1'b0));
        chk("a_tready_after_drain", 64'(a_tready), 64'(1'b1));
        chk("status_after_drain", 64'(status), 64'(2'b00));
    endtask

    task automatic random_frame();
        for (int i = 0; i < BEATS; i++) frame[i] = {$urandom, $urandom};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"transpose", 64'h1, 64'h2, 64'h3, 12'h321};
        tbl[1] = '{"mask_upper", 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF0,
                   64'hFFFF_FFFF_FFFF_FFF0, 12'h000};
        tbl[2] = '{"mixed_hi", 64'hABCD_0000_0000_0007, 64'h1234_5678_9ABC_DEF5,
                   64'h8000_0000_0000_000E, 12'hE57};
        tbl[3] = '{"all_ones", 64'hF, 64'hF, 64'hF, 12'hFFF};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_a_tready", 64'(a_tready), 64'(1'b0));
        chk("rst_x_tvalid", 64'(x_tvalid), 64'(1'b0));
        chk("rst_x_tlast", 64'(x_tlast), 64'(1'b0));
        chk("rst_x_tdata", 64'(x_tdata), 64'(12'h000));
        chk("rst_status", 64'(status), 64'(2'b00));
        RST = 1'b0;
        #1;
        chk("a_tready_before_first_edge", 64'(a_tready), 64'(1'b0));
        @(posedge CLK); #1;
        chk("a_tready_first_edge", 64'(a_tready), 64'(1'b1));

        // Full frame of index mod 16: every beat n comes out as {n,n,n}
        for (int i = 0; i < BEATS; i++) frame[i] = 64'(i % 16);
        push_frame(1'b0);
        for (int n = 0; n < N; n++) expv[n] = {n[3:0], n[3:0], n[3:0]};
        drain_frame(-1, 1'b0);

        foreach (tbl[t]) begin
            for (int i = 0; i < BEATS; i++) begin
                frame[i] = (i < N) ? tbl[t].w0 : (i < 2 * N) ? tbl[t].w1 : tbl[t].w2;
            end
            push_frame(1'b0);
            for (int n = 0; n < N; n++) expv[n] = tbl[t].exp;
            drain_frame(-1, 1'b0);
        end

        // Backpressure for three cycles at output index 7
        random_frame();
        push_frame(1'b0);
        drain_frame(7, 1'b0);

        // Input held valid during drain must be ignored
        random_frame();
        push_frame(1'b0);
        a_tdata  = 64'h5A5A_5A5A_5A5A_5A5A;
        a_tvalid = 1'b1;
        drain_frame(-1, 1'b1);
        a_tvalid = 1'b0;
        random_frame();
        push_frame(1'b0);
        drain_frame(-1, 1'b0);

        // Reset after 20 beats discards the partial frame
        random_frame();
        for (int i = 0; i < 20; i++) push_beat(frame[i]);
        chk("status_mid_fill", 64'(status), 64'(2'b01));
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("status_mid_reset", 64'(status), 64'(2'b00));
        chk("a_tready_mid_reset", 64'(a_tready), 64'(1'b0));
        chk("x_tvalid_mid_reset", 64'(x_tvalid), 64'(1'b0));
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        random_frame();
        push_frame(1'b0);
        drain_frame(-1, 1'b0);

        // Random frames with input gaps, downstream stalls and x_tready noise while filling
        for (int f = 0; f < 6; f++) begin
            random_frame();
            x_tready = 1'(f % 2);
            push_frame(1'b1);
            chk("x_tlast_not_early", 64'(x_tlast), 64'(1'b0));
            drain_frame(-1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/act_transposer.md
ACT_TRANSPOSER -- requirements
Module: act_transposer

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 16, neurons per image in one activation frame.
REQ-002 SHALL have parameter NUM_IMAGES, fixed 3, images per frame; matches the 3 x 4-bit x_tdata packing.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port a_tdata  input  64  activation beat; only bits [3:0] used, [63:4] ignored.
REQ-006 SHALL have port a_tvalid  input  1  activation beat valid.
REQ-007 SHALL have port a_tready  output  1  block can accept an activation beat.
REQ-008 SHALL have port x_tdata  output  12  {img2[n], img1[n], img0[n]}, 4 bits each, img0 in [3:0].
REQ-009 SHALL have port x_tvalid  output  1  x_tdata valid.
REQ-010 SHALL have port x_tready  input  1  downstream accepts x_tdata.
REQ-011 SHALL have port x_tlast  output  1  high on the beat for neuron NUM_NEURONS-1.
REQ-012 SHALL have port status  output  2  00 empty, 01 filling, 10 draining; 11 unused.

Function
REQ-013 SHALL hold a 3 x NUM_NEURONS x 4-bit buffer of registers, one frame deep.
REQ-014 SHALL use a two-state FSM: FILL (a_tready=1, x_tvalid=0) and DRAIN (a_tready=0, x_tvalid=1).
REQ-015 SHALL, in FILL, accept a beat only when a_tvalid & a_tready, writing a_tdata[3:0] to buf[img][neu].
REQ-016 SHALL expect input order: img0 neurons 0..N-1, then img1 0..N-1, then img2 0..N-1.
REQ-017 SHALL, per accepted beat, increment neu, wrap N-1 -> 0, and increment img on that wrap.
REQ-018 SHALL, on accepting beat img=2/neu=N-1, clear img/neu, enter DRAIN next cycle, and drop a_tready that same edge.
REQ-019 SHALL assert x_tvalid one cycle after the final input beat is accepted.
REQ-020 SHALL, in DRAIN, drive x_tdata = {buf[2][n], buf[1][n], buf[0][n]} with n = output index starting at 0.
REQ-021 SHALL hold x_tdata, x_tlast, x_tvalid stable while x_tvalid & ~x_tready.
REQ-022 SHALL advance n only on x_tvalid & x_tready; x_tlast = (n == N-1).
REQ-023 SHALL, on accepting n = N-1, clear n, return to FILL, deassert x_tvalid and assert a_tready on the same edge.
REQ-024 SHALL never accept input and emit output in the same cycle; no buffer overwrite during DRAIN.
REQ-025 SHALL drive status 00 in FILL with zero beats stored, 01 in FILL with >= 1 beat stored, 10 in DRAIN.
REQ-026 SHALL ignore a_tvalid while a_tready=0 and ignore x_tready while x_tvalid=0.
REQ-027 SHALL size counters: neu/n at $clog2(NUM_NEURONS) bits, img at 2 bits; no other arithmetic.

Reset
REQ-028 SHALL, while RST=1, force FILL, img=neu=n=0, a_tready=0, x_tvalid=0, x_tlast=0, x_tdata=0, status=00.
REQ-029 SHALL assert a_tready on the first rising edge after RST deasserts.
REQ-030 SHALL discard a partial frame or drain on reset mid-operation; buffer contents need not be cleared.

Verification
REQ-031 SHALL cover full frame: 48 beats, value = (index mod 16) -> 16 x beats; beat n = {n,n,n} nibbles, e.g. n=5 -> 12'h555; x_tlast on beat 15 only.
REQ-032 SHALL cover transpose: img0 all 4'h1, img1 all 4'h2, img2 all 4'h3 -> every x_tdata = 12'h321.
REQ-033 SHALL cover backpressure: x_tready low 3 cycles at n=7 -> x_tdata and x_tvalid held, no beat lost or duplicated.
REQ-034 SHALL cover input during DRAIN: a_tvalid held high -> a_tready=0, buffer unchanged; next frame accepted after x_tlast beat.
REQ-035 SHALL cover reset mid-fill: RST after 20 beats -> status=00; fresh 48-beat frame then drains correctly.
REQ-036 SHALL cover upper-bit masking: a_tdata=64'hFFFF_FFFF_FFFF_FFF0 for all beats -> every x_tdata = 12'h000.
